// File: rtl/tetris_pkg.sv
// Shared piece encoding, LFSR taps and generator state type for the Tetris piece generator.
`timescale 1ns/1ps
package tetris_pkg;

  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_e;

  localparam int          TYPE_NUM  = 7;
  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } gen_state_e;

  function automatic logic [2:0] lowest_unused(input logic [TYPE_NUM-1:0] mask);
    lowest_unused = 3'd0;
    for (int i = TYPE_NUM - 1; i >= 0; i--) begin
      if (!mask[i]) lowest_unused = 3'(i);
    end
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, free-running every cycle, with synchronous parallel load.
`timescale 1ns/1ps
module lfsr16 import tetris_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;

  always_comb begin
    if (load) q_d = load_val;
    else      q_d = (q_q >> 1) ^ (q_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= SEED;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/piece_generator.sv
// Tetris piece generator: LFSR-driven uniform or 7-bag source feeding a head+preview FIFO.
//   state   | meaning
//   ST_FILL | queue has a free slot, generate every cycle
//   ST_FULL | queue full, generate only when the head is popped
`timescale 1ns/1ps
module piece_generator import tetris_pkg::*; #(
  parameter int          BOARD_W       = 10,
  parameter int          X_W           = 4,
  parameter int          Y_W           = 5,
  parameter int          PREVIEW_DEPTH = 3,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mode,
  input  logic                       seed_load,
  input  logic [15:0]                seed_in,
  input  logic                       req,
  output logic                       piece_valid,
  output logic [2:0]                 piece_type,
  output logic [X_W-1:0]             piece_x,
  output logic [Y_W-1:0]             piece_y,
  output logic [3*PREVIEW_DEPTH-1:0] preview_types,
  output logic [2:0]                 queue_count
);

  localparam int             Q       = PREVIEW_DEPTH + 1;
  localparam logic [2:0]     Q_CNT   = 3'(Q);
  localparam logic [X_W-1:0] SPAWN_X = X_W'((BOARD_W - 4) / 2);

  gen_state_e          state_q, state_d;
  logic [2:0]          queue_q [Q];
  logic [2:0]          queue_d [Q];
  logic [2:0]          count_q, count_d;
  logic [TYPE_NUM-1:0] mask_q, mask_d;
  logic                mode_q;

  logic [15:0]         lfsr_q;
  logic [15:0]         load_val;
  logic                lfsr_unused;
  logic                pop, gen, push;
  logic [2:0]          cand, new_type, count_pop;
  logic [TYPE_NUM-1:0] eff_mask, new_mask;
  logic [TYPE_NUM:0]   used8;

  assign load_val    = (seed_in == 16'h0000) ? SEED : seed_in;
  assign lfsr_unused = ^lfsr_q[15:3];

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seed_load),
    .load_val (load_val),
    .q        (lfsr_q)
  );

  always_comb begin
    pop       = req && (count_q != 3'd0) && !seed_load;
    gen       = !seed_load && ((state_q == ST_FILL) || pop);
    cand      = lfsr_q[2:0];
    // A mode switch starts a fresh bag; queued entries are untouched.
    eff_mask  = (mode != mode_q) ? '0 : mask_q;
    used8     = {1'b1, eff_mask};
    new_type  = cand;
    push      = 1'b0;
    mask_d    = eff_mask;
    if (gen) begin
      if (mode) begin
        if (used8[cand]) new_type = lowest_unused(eff_mask);
        push = 1'b1;
      end else begin
        push = (cand != 3'd7);
      end
    end
    new_mask = eff_mask | (7'b000_0001 << new_type);
    if (push && mode) mask_d = (new_mask == '1) ? '0 : new_mask;

    count_pop = count_q - {2'b00, pop};
    for (int i = 0; i < Q - 1; i++) queue_d[i] = pop ? queue_q[i+1] : queue_q[i];
    queue_d[Q-1] = pop ? 3'd0 : queue_q[Q-1];
    for (int i = 0; i < Q; i++) begin
      if (push && (count_pop == 3'(i))) queue_d[i] = new_type;
    end
    count_d = count_pop + {2'b00, push};

    if (seed_load) begin
      for (int i = 0; i < Q; i++) queue_d[i] = 3'd0;
      count_d = 3'd0;
      mask_d  = '0;
    end

    state_d = (count_d == Q_CNT) ? ST_FULL : ST_FILL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      count_q <= 3'd0;
      mask_q  <= '0;
      mode_q  <= 1'b0;
      for (int i = 0; i < Q; i++) queue_q[i] <= 3'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mask_q  <= mask_d;
      mode_q  <= mode;
      for (int i = 0; i < Q; i++) queue_q[i] <= queue_d[i];
    end
  end

  always_comb begin
    preview_types = '0;
    for (int k = 0; k < PREVIEW_DEPTH; k++) preview_types[3*k +: 3] = queue_q[k+1];
  end

  assign piece_valid = (count_q != 3'd0);
  assign piece_type  = queue_q[0];
  assign piece_x     = piece_valid ? SPAWN_X : '0;
  assign piece_y     = '0;
  assign queue_count = count_q;

endmodule
